// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the frame write scheduler slice.
//   - state_t          : scheduler FSM states (IDLE, GRANT, STREAM, DONE)
//   - DATA_W_DEF       : default pixel byte width
//   - FRAME_BYTES_DEF  : default bytes per frame (100x100 headless 24-bit BMP)
//   - SRC_LIVE/SRC_PATTERN : source indices (live frame buffer, test pattern)
//   - src_onehot()     : source index -> one-hot grant vector
// -----------------------------------------------------------------------------
package frame_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int FRAME_BYTES_DEF = 30000;

    localparam int SRC_LIVE    = 0;
    localparam int SRC_PATTERN = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [1:0] src_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin pick.
//   req     in  2 : per-source request
//   rr_last in  1 : index of the source granted most recently
//   winner  out 2 : one-hot winner, 0 when nobody requests
// On a tie the source that was not granted last wins.
// -----------------------------------------------------------------------------
module rr_arbiter2
    import frame_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] winner
);

    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = src_onehot(!rr_last);
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/frame_write_scheduler.sv
// -----------------------------------------------------------------------------
// frame_write_scheduler
// Grants one of two pixel-byte sources to the image writer, round-robin, and
// streams exactly FRAME_BYTES bytes from it before re-arbitrating.
//
// Ports:
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   req[1:0]              : per-source frame request (sampled in IDLE only)
//   src_data[2*DATA_W-1:0]: src0 byte in low lane, src1 byte in high lane
//   src_valid[1:0]        : per-source byte valid
//   src_ready[1:0]        : per-source ready, only the granted bit can be set
//   wr_stall              : writer backpressure (1 = no transfer)
//   wr_data, wr_en        : byte to writer, registered one cycle after handshake
//   grant[1:0]            : one-hot owner, 0 when idle
//   busy                  : high in GRANT/STREAM/DONE
//   frame_done            : one-cycle pulse alongside the last byte's wr_en
//   byte_count            : bytes transferred in the current frame
//
// Optional build macro FRAME_CHECKSUM_EN adds frame_sum[15:0], the modulo-2^16
// sum of the frame's bytes, valid from frame_done until the next GRANT.
// -----------------------------------------------------------------------------
module frame_write_scheduler
    import frame_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int CNT_W       = $clog2(FRAME_BYTES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [2*DATA_W-1:0] src_data,
    input  logic [1:0]          src_valid,
    output logic [1:0]          src_ready,
    input  logic                wr_stall,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_en,
    output logic [1:0]          grant,
    output logic                busy,
    output logic                frame_done,
    output logic [CNT_W-1:0]    byte_count
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [15:0]         frame_sum
`endif
);

    state_t              state_reg;
    state_t              state_next;
    logic [1:0]          grant_reg;
    logic                rr_last_reg;
    logic [DATA_W-1:0]   wr_data_reg;
    logic                wr_en_reg;
    logic                frame_done_reg;
    logic [CNT_W-1:0]    byte_count_reg;

    logic [1:0]          winner;
    logic [1:0]          ready_vec;
    logic [1:0]          xfer_vec;
    logic [DATA_W-1:0]   byte_vec [2];
    logic [DATA_W-1:0]   sel_byte;
    logic                xfer;
    logic                last_byte;

    rr_arbiter2 u_arb (
        .req     (req),
        .rr_last (rr_last_reg),
        .winner  (winner)
    );

    // Per-source ready/handshake lanes; only the granted lane can be ready.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign ready_vec[gi] = (state_reg == STREAM) && grant_reg[gi] && !wr_stall;
        assign xfer_vec[gi]  = ready_vec[gi] && src_valid[gi];
        assign byte_vec[gi]  = src_data[gi*DATA_W +: DATA_W];
    end

    assign xfer      = |xfer_vec;
    assign sel_byte  = grant_reg[SRC_PATTERN] ? byte_vec[SRC_PATTERN] : byte_vec[SRC_LIVE];
    assign last_byte = (byte_count_reg == CNT_W'(FRAME_BYTES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req != 2'b00) state_next = GRANT;
            GRANT:   state_next = STREAM;
            STREAM:  if (xfer && last_byte) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_reg      <= 2'b00;
            rr_last_reg    <= 1'b1;     // src0 wins the first tie
            wr_data_reg    <= '0;
            wr_en_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            byte_count_reg <= '0;
        end else begin
            wr_en_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req != 2'b00) grant_reg <= winner;
                end
                GRANT: begin
                    byte_count_reg <= '0;
                end
                STREAM: begin
                    if (xfer) begin
                        wr_data_reg    <= sel_byte;
                        wr_en_reg      <= 1'b1;
                        byte_count_reg <= byte_count_reg + CNT_W'(1);
                        // Pulse lands in the same cycle as the last byte's wr_en
                        if (last_byte) frame_done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    rr_last_reg <= grant_reg[SRC_PATTERN];
                    grant_reg   <= 2'b00;
                end
                default: ;
            endcase
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] frame_sum_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_sum_reg <= '0;
        end else if (state_reg == GRANT) begin
            frame_sum_reg <= '0;
        end else if (state_reg == STREAM && xfer) begin
            frame_sum_reg <= frame_sum_reg + 16'(sel_byte);
        end
    end

    assign frame_sum = frame_sum_reg;
`endif

    assign src_ready  = ready_vec;
    assign wr_data    = wr_data_reg;
    assign wr_en      = wr_en_reg;
    assign grant      = grant_reg;
    assign busy       = (state_reg != IDLE);
    assign frame_done = frame_done_reg;
    assign byte_count = byte_count_reg;

endmodule

// File: tb/tb_frame_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_write_scheduler
// Directed bench: a small instance (FRAME_BYTES=8) for protocol scenarios and
// a default-size instance (30000 bytes) for the full-frame count.
// Source model: src0 emits 0x10,0x11,... and src1 emits 0xA0,0xA1,...,
// advancing on each handshake. Expected writer bytes are queued by hand.
// -----------------------------------------------------------------------------
module tb_frame_write_scheduler;

    localparam int FB     = 8;
    localparam int CW     = $clog2(FB + 1);
    localparam int BIG_FB = 30000;
    localparam int BIG_CW = $clog2(BIG_FB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance
    logic            reset;
    logic [1:0]      req;
    logic [15:0]     src_data;
    logic [1:0]      src_valid;
    logic [1:0]      src_ready;
    logic            wr_stall;
    logic [7:0]      wr_data;
    logic            wr_en;
    logic [1:0]      grant;
    logic            busy;
    logic            frame_done;
    logic [CW-1:0]   byte_count;
`ifdef FRAME_CHECKSUM_EN
    logic [15:0]     frame_sum;
`endif

    // Default-size instance
    logic              big_reset;
    logic [1:0]        big_req;
    logic [15:0]       big_src_data;
    logic [1:0]        big_src_valid;
    logic [1:0]        big_src_ready;
    logic              big_wr_stall;
    logic [7:0]        big_wr_data;
    logic              big_wr_en;
    logic [1:0]        big_grant;
    logic              big_busy;
    logic              big_frame_done;
    logic [BIG_CW-1:0] big_byte_count;
`ifdef FRAME_CHECKSUM_EN
    logic [15:0]       big_frame_sum;
`endif

    frame_write_scheduler #(.DATA_W(8), .FRAME_BYTES(FB)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .wr_stall   (wr_stall),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .grant      (grant),
        .busy       (busy),
        .frame_done (frame_done),
        .byte_count (byte_count)
`ifdef FRAME_CHECKSUM_EN
        ,
        .frame_sum  (frame_sum)
`endif
    );

    frame_write_scheduler u_big (
        .clk        (clk),
        .reset      (big_reset),
        .req        (big_req),
        .src_data   (big_src_data),
        .src_valid  (big_src_valid),
        .src_ready  (big_src_ready),
        .wr_stall   (big_wr_stall),
        .wr_data    (big_wr_data),
        .wr_en      (big_wr_en),
        .grant      (big_grant),
        .busy       (big_busy),
        .frame_done (big_frame_done),
        .byte_count (big_byte_count)
`ifdef FRAME_CHECKSUM_EN
        ,
        .frame_sum  (big_frame_sum)
`endif
    );

    int total = 0;
    int bad   = 0;

    int         cnt0, cnt1, t, wr_cnt, done_cnt, at;
    bit         ff_mode;
    logic [7:0] exp_q[$];
    logic [1:0] grant_q[$];
    logic [1:0] prev_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        src_data = {8'hA0 + 8'(cnt1), ff_mode ? 8'hFF : 8'h10 + 8'(cnt0)};
    endtask

    // Post-edge monitor for the small instance
    task automatic observe();
        if (wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) chk("wr_extra_byte", 32'(wr_data), 32'h100);
            else                   chk("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
        end
        if (frame_done) begin
            done_cnt++;
            $display("frame done: grant=%b bytes=%0d t=%0d", grant, byte_count, t);
            chk("done_with_wr_en", 32'(wr_en), 32'd1);
            chk("done_byte_count", 32'(byte_count), 32'(FB));
        end
        if (grant != 2'b00 && prev_grant == 2'b00) grant_q.push_back(grant);
        prev_grant = grant;
    endtask

    // One clock: record handshakes mid-cycle, then sample outputs after the edge
    task automatic tick();
        bit hs0, hs1;
        @(negedge clk);
        hs0 = !reset && src_valid[0] && src_ready[0];
        hs1 = !reset && src_valid[1] && src_ready[1];
        @(posedge clk);
        #1;
        t++;
        if (hs0) cnt0++;
        if (hs1) cnt1++;
        drive();
        observe();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 2'b00;
        wr_stall = 1'b0;
        src_valid = 2'b11;
        tick();
        tick();
        reset = 1'b0;
        cnt0 = 0; cnt1 = 0; t = 0; wr_cnt = 0; done_cnt = 0;
        prev_grant = 2'b00;
        exp_q.delete();
        grant_q.delete();
        drive();
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 8'(i));
    endtask

    task automatic run_frames(input int n, input int max_ticks);
        int start;
        start = done_cnt;
        for (int i = 0; i < max_ticks; i++) begin
            if (done_cnt - start >= n) break;
            tick();
        end
        chk("frames_within_bound", 32'(done_cnt - start), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ff_mode = 1'b0;
        cnt0 = 0; cnt1 = 0;
        src_data = 16'h0;
        big_reset = 1'b1; big_req = 2'b00; big_src_data = 16'h005A;
        big_src_valid = 2'b01; big_wr_stall = 1'b0;

        // ---- reset state + single src0 frame ----
        do_reset();
        chk("rst_src_ready", 32'(src_ready), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_byte_count", 32'(byte_count), 32'd0);

        push_seq(8'h10, FB);
        req = 2'b01;
        tick();
        req = 2'b00;
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_busy", 32'(busy), 32'd1);
        run_frames(1, 40);
        chk("t1_done_time", 32'(t), 32'd10);
        chk("t1_wr_cnt", 32'(wr_cnt), 32'(FB));
        tick();
        chk("t1_grant_after", 32'(grant), 32'h0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_done_pulse", 32'(frame_done), 32'd0);
        chk("t1_count_hold", 32'(byte_count), 32'(FB));

        // ---- both requesting: alternation ----
        do_reset();
        push_seq(8'h10, FB);
        push_seq(8'hA0, FB);
        push_seq(8'h18, FB);
        req = 2'b11;
        run_frames(3, 100);
        req = 2'b00;
        chk("t2_done_time", 32'(t), 32'd32);
        chk("t2_done_cnt", 32'(done_cnt), 32'd3);
        chk("t2_wr_cnt", 32'(wr_cnt), 32'(3 * FB));
        chk("t2_grants_n", 32'(grant_q.size()), 32'd3);
        if (grant_q.size() == 3) begin
            chk("t2_grant0", 32'(grant_q[0]), 32'h1);
            chk("t2_grant1", 32'(grant_q[1]), 32'h2);
            chk("t2_grant2", 32'(grant_q[2]), 32'h1);
        end
        tick();
        tick();
        chk("t2_idle_after", 32'(busy), 32'd0);

        // ---- stall after byte 3 ----
        do_reset();
        push_seq(8'h10, FB);
        req = 2'b01;
        tick();
        req = 2'b00;
        for (int i = 0; i < 20 && cnt0 < 3; i++) tick();
        chk("t3_stall_start", 32'(t), 32'd5);
        wr_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_ready", 32'(src_ready), 32'd0);
            chk("t3_stall_count", 32'(byte_count), 32'd3);
            chk("t3_stall_wr_en", 32'(wr_en), 32'd0);
        end
        chk("t3_stall_busy", 32'(busy), 32'd1);
        wr_stall = 1'b0;
        run_frames(1, 40);
        chk("t3_done_time", 32'(t), 32'd15);
        chk("t3_wr_cnt", 32'(wr_cnt), 32'(FB));

        // ---- reset mid-frame, then src1 frame ----
        do_reset();
        push_seq(8'h10, FB);
        req = 2'b01;
        tick();
        req = 2'b00;
        for (int i = 0; i < 20 && cnt0 < 4; i++) tick();
        chk("t4_bytes_before", 32'(wr_cnt), 32'd4);
        reset = 1'b1;
        tick();
        chk("t4_rst_grant", 32'(grant), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_wr_en", 32'(wr_en), 32'd0);
        chk("t4_rst_count", 32'(byte_count), 32'd0);
        chk("t4_rst_wr_data", 32'(wr_data), 32'd0);
        chk("t4_no_done", 32'(done_cnt), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        grant_q.delete();
        cnt1 = 0; t = 0; wr_cnt = 0; done_cnt = 0;
        drive();
        push_seq(8'hA0, FB);
        req = 2'b10;
        tick();
        req = 2'b00;
        chk("t4_grant", 32'(grant), 32'h2);
        run_frames(1, 40);
        chk("t4_wr_cnt", 32'(wr_cnt), 32'(FB));
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);

        // ---- src1 noise during a src0 frame ----
        do_reset();
        push_seq(8'h10, FB);
        req = 2'b11;
        tick();
        req = 2'b00;
        chk("t5_grant", 32'(grant), 32'h1);
        for (int i = 0; i < 40 && done_cnt < 1; i++) begin
            src_valid[1] = ~src_valid[1];
            tick();
            chk("t5_src1_ready", 32'(src_ready[1]), 32'd0);
        end
        src_valid = 2'b11;
        chk("t5_done_time", 32'(t), 32'd10);
        chk("t5_src1_untouched", 32'(cnt1), 32'd0);
        chk("t5_wr_cnt", 32'(wr_cnt), 32'(FB));

`ifdef FRAME_CHECKSUM_EN
        // ---- checksum of eight 0xFF bytes ----
        do_reset();
        ff_mode = 1'b1;
        drive();
        for (int i = 0; i < FB; i++) exp_q.push_back(8'hFF);
        req = 2'b01;
        tick();
        req = 2'b00;
        run_frames(1, 40);
        chk("t6_frame_sum", 32'(frame_sum), 32'h07F8);
        tick();
        chk("t6_sum_stable", 32'(frame_sum), 32'h07F8);
        ff_mode = 1'b0;
`endif

        // ---- default-size frame: 30000 bytes ----
        @(posedge clk); #1;
        big_reset = 1'b0;
        big_req = 2'b01;
        @(posedge clk); #1;
        big_req = 2'b00;
        begin
            int big_wr;
            big_wr = 0;
            at = -1;
            for (int i = 0; i < 31000; i++) begin
                if (big_wr_en) big_wr++;
                if (big_frame_done) begin
                    at = big_wr;
                    break;
                end
                @(posedge clk); #1;
            end
            $display("big frame: wr_en pulses at frame_done=%0d", at);
            chk("big_wr_at_done", 32'(at), 32'd30000);
            chk("big_byte_count", 32'(big_byte_count), 32'd30000);
            chk("big_wr_data", 32'(big_wr_data), 32'h5A);
            chk("big_busy", 32'(big_busy), 32'd1);
            chk("big_grant", 32'(big_grant), 32'h1);
            chk("big_src_ready", 32'(big_src_ready), 32'd0);
`ifdef FRAME_CHECKSUM_EN
            chk("big_frame_sum", 32'(big_frame_sum), 32'h32E0);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
